mult_arbiter: RTL and testbench

- Sequencer and round-robin arbiter that shares one 16x16 shift-add Multiplicador between two requesters (e.g. ALU MULT path and address/debug unit).
- Owns the multiplier's St pulse, latches operands, waits for Done with a watchdog, and returns the 32-bit product to the winning requester.
- Sits between the requesters and the Multiplicador instance in the datapath.

---
 rtl/mult_pkg.sv | 18 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mult_arbiter.sv | 127 ++++++++++++
 tb/tb_mult_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequencer that time-shares one 16x16 shift-add multiplier.
package mult_pkg;

  localparam int MULT_W       = 16;
  localparam int MULT_TIMEOUT = 48;
  localparam int MULT_CW      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWNER0 = 1'b0;
  localparam logic OWNER1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_id = gnt[1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer in front of one shared multiplier: latches operands, pulses St,
// waits for Done under a watchdog and hands the product back to the requester that won.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int W       = MULT_W,
  parameter int TIMEOUT = MULT_TIMEOUT,
  parameter int CW      = MULT_CW
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Req0,
  input  logic           Req1,
  input  logic [W-1:0]   A0,
  input  logic [W-1:0]   B0,
  input  logic [W-1:0]   A1,
  input  logic [W-1:0]   B1,
  output logic           Ack0,
  output logic           Ack1,
  output logic           Vld0,
  output logic           Vld1,
  output logic [2*W-1:0] Res,
  output logic           Err,
  output logic           Busy,
  output logic           Mul_St,
  output logic [W-1:0]   Mul_A,
  output logic [W-1:0]   Mul_B,
  input  logic           Mul_Idle,
  input  logic           Mul_Done,
  input  logic [2*W-1:0] Mul_Prod,
  output state_t         Dbg_State
);

  // Handshake: a requester holds Req plus operands until it sees its one-cycle Ack, then
  // drops Req; dropping earlier withdraws the request. Vld is a one-cycle pulse, and
  // Res/Err are only meaningful while Vld is high.

  state_t          state_q, state_nx;
  logic            owner_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  res_q;
  logic            err_q;
  logic [1:0]      gnt;
  logic            gnt_id;
  logic            accept;
  logic            done_ok;
  logic            timeout;

  rr_arb2 u_arb (
    .req    ({Req1, Req0}),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept  = Mul_Idle && (Req0 || Req1);
  // Done during the first WAIT cycle may be left over from the previous operation.
  assign done_ok = (cnt_q != '0) && Mul_Done;
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (accept) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (done_ok || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Ack0   = (state_q == START) && (owner_q == OWNER0);
    Ack1   = (state_q == START) && (owner_q == OWNER1);
    Vld0   = (state_q == RESP)  && (owner_q == OWNER0);
    Vld1   = (state_q == RESP)  && (owner_q == OWNER1);
    Mul_St = (state_q == START);
    Busy   = (state_q != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      owner_q <= OWNER0;
      last_q  <= OWNER1;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      Mul_A   <= '0;
      Mul_B   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= gnt_id;
            Mul_A   <= gnt_id ? A1 : A0;
            Mul_B   <= gnt_id ? B1 : B0;
          end
        end
        START: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A real Done wins over the watchdog when both land on the same cycle.
          if (done_ok) begin
            res_q <= Mul_Prod;
            err_q <= 1'b0;
          end else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESP:    last_q <= owner_q;
        default: ;
      endcase
    end
  end

  assign Res       = res_q;
  assign Err       = err_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural shift-add multiplier model.
module tb_mult_arbiter;
  import mult_pkg::*;

  localparam int W       = 16;
  localparam int TIMEOUT = 48;

  logic           Clk, Reset;
  logic           Req0, Req1;
  logic [W-1:0]   A0, B0, A1, B1;
  logic           Ack0, Ack1, Vld0, Vld1;
  logic [2*W-1:0] Res;
  logic           Err, Busy, Mul_St;
  logic [W-1:0]   Mul_A, Mul_B;
  logic           Mul_Idle, Mul_Done;
  logic [2*W-1:0] Mul_Prod;
  state_t         dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Multiplier model controls
  int             lat;
  logic           never_done;
  logic           force_done;
  logic           force_idle_low;
  logic           m_busy, m_done;
  int             m_cnt;
  logic [2*W-1:0] m_res, m_prod;

  mult_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .CW(6)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req0      (Req0),
    .Req1      (Req1),
    .A0        (A0),
    .B0        (B0),
    .A1        (A1),
    .B1        (B1),
    .Ack0      (Ack0),
    .Ack1      (Ack1),
    .Vld0      (Vld0),
    .Vld1      (Vld1),
    .Res       (Res),
    .Err       (Err),
    .Busy      (Busy),
    .Mul_St    (Mul_St),
    .Mul_A     (Mul_A),
    .Mul_B     (Mul_B),
    .Mul_Idle  (Mul_Idle),
    .Mul_Done  (Mul_Done),
    .Mul_Prod  (Mul_Prod),
    .Dbg_State (dbg_state)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Multiplier: Done rises lat cycles after St is sampled; product changes only on Done.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (Mul_St) begin
        m_busy <= 1'b1;
        m_cnt  <= lat;
        m_res  <= 32'(Mul_A) * 32'(Mul_B);
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          if (!never_done) begin
            m_done <= 1'b1;
            m_prod <= m_res;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign Mul_Idle = !m_busy && !force_idle_low;
  assign Mul_Done = m_done || force_done;
  assign Mul_Prod = m_prod;

  // Ack/Vld exclusivity holds on every cycle out of reset.
  always @(negedge Clk) begin
    if (Reset) begin
      n_cmp++;
      assert (!(Ack0 && Ack1) && !(Vld0 && Vld1) && !((Ack0 || Ack1) && (Vld0 || Vld1)))
      else begin
        n_err++;
        $error("FAIL excl observed ack=%b%b vld=%b%b expected at most one of them high",
               Ack1, Ack0, Vld1, Vld0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed no finish expected finish before 100us");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_ack(input string tag, input int maxc, output logic who, output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!(Ack0 || Ack1) && cyc < maxc);
    who = Ack1;
    n_cmp++;
    assert (Ack0 || Ack1)
    else begin
      n_err++;
      $error("FAIL %s observed no Ack expected Ack within %0d cycles", tag, maxc);
    end
  endtask

  task automatic wait_vld(input string tag, input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!(Vld0 || Vld1) && cyc < maxc);
    n_cmp++;
    assert (Vld0 || Vld1)
    else begin
      n_err++;
      $error("FAIL %s observed no Vld expected Vld within %0d cycles", tag, maxc);
    end
  endtask

  task automatic reset_dut();
    Reset = 1'b0;
    step(2);
    Reset = 1'b1;
    step(1);
  endtask

  initial begin
    logic who;
    int   cyc;
    logic seen;
    logic [0:0]  exp_who [4];
    logic [31:0] exp_res [4];

    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    lat = 4; never_done = 1'b0; force_done = 1'b0; force_idle_low = 1'b0;

    // Reset values
    step(2);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_ack", 64'({Ack1, Ack0}), 64'd0);
    chk("rst_res", 64'(Res), 64'd0);
    chk("rst_mula", 64'(Mul_A), 64'd0);
    Reset = 1'b1;
    step(1);

    // Reset asserted mid-WAIT aborts silently
    Req0 = 1'b1; A0 = 16'd300; B0 = 16'd7;
    wait_ack("t1_ack", 5, who, cyc);
    Req0 = 1'b0;
    step(2);
    chk("t1_busy_wait", 64'(Busy), 64'd1);
    Reset = 1'b0;
    #1;
    chk("t1_rst_outs", 64'({Busy, Mul_St, Ack0, Ack1, Vld0, Vld1, Err}), 64'd0);
    chk("t1_rst_mula", 64'(Mul_A), 64'd0);
    chk("t1_rst_res", 64'(Res), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      seen = seen | Vld0 | Ack0;
    end
    chk("t1_no_vld", 64'(seen), 64'd0);
    Reset = 1'b1;
    step(1);
    Req0 = 1'b1; A0 = 16'd12; B0 = 16'd12;
    wait_ack("t1b_ack", 5, who, cyc);
    chk("t1b_ack_lat", 64'(cyc), 64'd1);
    Req0 = 1'b0;
    wait_vld("t1b_vld", 20, cyc);
    chk("t1b_vld_lat", 64'(cyc), 64'(lat + 2));
    chk("t1b_vld0", 64'({Vld1, Vld0}), 64'b01);
    chk("t1b_res", 64'(Res), 64'd144);
    chk("t1b_err", 64'(Err), 64'd0);

    // Single Req0 with the largest operands
    step(1);
    Req0 = 1'b1; A0 = 16'hFFFF; B0 = 16'hFFFF;
    wait_ack("t2_ack", 5, who, cyc);
    chk("t2_ack_lat", 64'(cyc), 64'd1);
    chk("t2_st", 64'(Mul_St), 64'd1);
    chk("t2_mula", 64'(Mul_A), 64'hFFFF);
    Req0 = 1'b0;
    step(1);
    chk("t2_st_once", 64'({Mul_St, Ack0}), 64'd0);
    chk("t2_busy", 64'(Busy), 64'd1);
    wait_vld("t2_vld", 20, cyc);
    chk("t2_vld_lat", 64'(cyc + 1), 64'(lat + 2));
    chk("t2_vld0", 64'({Vld1, Vld0}), 64'b01);
    chk("t2_res", 64'(Res), 64'hFFFE0001);
    chk("t2_err", 64'(Err), 64'd0);
    step(1);
    chk("t2_busy_after", 64'(Busy), 64'd0);

    // Simultaneous requests from reset: requester 0 first
    reset_dut();
    Req0 = 1'b1; A0 = 16'd3; B0 = 16'd5;
    Req1 = 1'b1; A1 = 16'd7; B1 = 16'd9;
    wait_ack("t3_ack0", 5, who, cyc);
    chk("t3_first", 64'({Ack1, Ack0}), 64'b01);
    Req0 = 1'b0;
    wait_vld("t3_vld0", 20, cyc);
    chk("t3_vld0", 64'({Vld1, Vld0}), 64'b01);
    chk("t3_res0", 64'(Res), 64'd15);
    step(1);
    chk("t3_gap_idle", 64'(Busy), 64'd0);
    step(1);
    chk("t3_second", 64'({Ack1, Ack0}), 64'b10);
    chk("t3_mula1", 64'(Mul_A), 64'd7);
    Req1 = 1'b0;
    wait_vld("t3_vld1", 20, cyc);
    chk("t3_vld1", 64'({Vld1, Vld0}), 64'b10);
    chk("t3_res1", 64'(Res), 64'd63);

    // Continuous contention: strict alternation (last served was requester 1)
    exp_who[0] = 1'b0; exp_res[0] = 32'd0;
    exp_who[1] = 1'b1; exp_res[1] = 32'd65535;
    exp_who[2] = 1'b0; exp_res[2] = 32'd7006652;
    exp_who[3] = 1'b1; exp_res[3] = 32'd65536;
    Req0 = 1'b1; A0 = 16'd0;     B0 = 16'd0;
    Req1 = 1'b1; A1 = 16'd65535; B1 = 16'd1;
    for (int i = 0; i < 4; i++) begin
      wait_ack("t4_ack", 10, who, cyc);
      chk("t4_owner", 64'(who), 64'(exp_who[i]));
      if (who) Req1 = 1'b0;
      else     Req0 = 1'b0;
      step(1);
      if (i < 2) begin
        if (exp_who[i] == 1'b0) begin
          Req0 = 1'b1; A0 = 16'd1234; B0 = 16'd5678;
        end else begin
          Req1 = 1'b1; A1 = 16'd256; B1 = 16'd256;
        end
      end
      wait_vld("t4_vld", 20, cyc);
      chk("t4_vld_owner", 64'({Vld1, Vld0}), exp_who[i] ? 64'b10 : 64'b01);
      chk("t4_res", 64'(Res), 64'(exp_res[i]));
    end

    // Multiplier never raises Done: watchdog abort, then a normal op
    step(1);
    never_done = 1'b1;
    Req0 = 1'b1; A0 = 16'd10; B0 = 16'd10;
    wait_ack("t5_ack", 5, who, cyc);
    Req0 = 1'b0;
    wait_vld("t5_vld", 100, cyc);
    chk("t5_vld_lat", 64'(cyc), 64'(TIMEOUT + 1));
    chk("t5_vld0", 64'({Vld1, Vld0}), 64'b01);
    chk("t5_err", 64'(Err), 64'd1);
    chk("t5_res", 64'(Res), 64'd0);
    step(1);
    chk("t5_err_hold", 64'(Err), 64'd1);
    chk("t5_idle", 64'(Busy), 64'd0);
    never_done = 1'b0;
    Req0 = 1'b1; A0 = 16'd6; B0 = 16'd7;
    wait_ack("t5b_ack", 5, who, cyc);
    Req0 = 1'b0;
    wait_vld("t5b_vld", 20, cyc);
    chk("t5b_res", 64'(Res), 64'd42);
    chk("t5b_err", 64'(Err), 64'd0);

    // Mul_Idle low holds off Ack; stale Done in first WAIT cycle is ignored
    step(1);
    force_idle_low = 1'b1; force_done = 1'b1;
    Req1 = 1'b1; A1 = 16'd9; B1 = 16'd11;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      seen = seen | Ack1 | Busy;
    end
    chk("t6_hold_idle", 64'(seen), 64'd0);
    force_idle_low = 1'b0;
    step(1);
    chk("t6_ack1", 64'({Ack1, Ack0}), 64'b10);
    Req1 = 1'b0;
    step(2);
    chk("t6_stale_ignored", 64'({Busy, Vld1}), 64'b10);
    force_done = 1'b0;
    wait_vld("t6_vld", 20, cyc);
    chk("t6_vld1", 64'({Vld1, Vld0}), 64'b10);
    chk("t6_res", 64'(Res), 64'd99);
    chk("t6_err", 64'(Err), 64'd0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
